signed_calc_seq: RTL and testbench
==================================

Name: signed_calc_seq

Overview:
- Parametrised, clocked successor to the combinational signed calculator.
- Accepts two W-bit signed operands and an opcode over a valid/ready handshake, and returns a registered 2W-bit signed result.
- Supports add, sub, multiply and multiply-accumulate (MAC).
- Multiply uses an iterative shift-add datapath, one bit per cycle. MAC adds a saturating accumulator with a sticky overflow flag.

Parameters:
- W, 5, operand width in bits (signed two's complement); W >= 2
- ACC_W, 12, MAC accumulator width in bits (signed); ACC_W >= 2*W

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_valid  in  1  request valid
- o_ready  out  1  block can accept a request
- i_op  in  2  00 add, 01 sub, 10 mul, 11 mac
- i_as  in  W  signed operand a
- i_bs  in  W  signed operand b
- i_acc_clr  in  1  synchronous clear of accumulator and overflow flag
- o_valid  out  1  o_fs/o_acc/o_ovf hold a valid result
- i_ready  in  1  consumer accepts result
- o_fs  out  2W  signed result, sign-extended
- o_acc  out  ACC_W  signed accumulator value
- o_ovf  out  1  sticky: accumulator saturated since last clear

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=IDLE, o_valid=0, o_fs=0, o_acc=0, o_ovf=0. o_ready=1 once reset deasserts. Reset in any state aborts the operation in flight with no output.
- o_ready = (state==IDLE). A request is accepted on a rising edge with i_valid & o_ready. Operands and op are captured at that edge.
- IDLE, accept add/sub: next state DONE; o_fs = sext(a) ± sext(b) computed at full 2W width, so no overflow. o_valid=1 on the cycle after accept.
- IDLE, accept mul/mac: next state MUL.
  - Registers: |a| and |b| as W-bit unsigned (|-2^(W-1)| = 2^(W-1) fits), sign = a[W-1]^b[W-1], cnt=0, partial product = 0.
- MUL: each cycle, if bit cnt of |b| is set, add |a|<<cnt to the partial product; then cnt++.
  - After W iterations, next state DONE, with o_fs = sign ? -pp : pp.
  - o_valid rises W+1 cycles after the accept edge.
- MAC: on the MUL->DONE transition, acc <= sat(acc + sext(product)).
  - Saturation limits are +2^(ACC_W-1)-1 and -2^(ACC_W-1).
  - o_ovf is set if saturation clamps; it stays set (sticky).
- DONE: o_valid=1; outputs are held stable while i_ready=0. When i_ready=1, next state is IDLE and o_valid=0. A new request is accepted no earlier than the cycle after that, so there are no back-to-back accepts.
- i_acc_clr: acc <= 0 and o_ovf <= 0 on the next edge, in any state.
  - If asserted on the same edge as a MAC update, the clear wins and the product is discarded from the accumulator. o_fs still returns the product.
- i_valid while o_ready=0 is ignored; the requester must hold the request.
- Any i_op value outside the encoding does not occur (encoding is complete).
- o_acc always reflects the accumulator register.

Decomposition:
- Package signed_calc_pkg holds the op encodings (OP_ADD, OP_SUB, OP_MUL, OP_MAC), the FSM state enum (IDLE, MUL, DONE), and a sat function parametrised by width.
- One sub-module, signed_mul_iter: start/done iterative W-bit signed multiplier (magnitude shift-add plus sign fix-up). The top handles the handshake, add/sub and the accumulator.

Test Plan (W=5; ACC_W=10 for the overflow case):
- Reset mid-MUL: request mul -15*15, pull i_rst_n low at cycle 2 -> o_valid=0, o_fs=0, o_acc=0 immediately; o_ready=1 after release; no stale result appears.
- Add/sub: add 15+15 -> o_fs=30, o_valid one cycle after accept; sub -16-15 -> o_fs=-31; add 0+0 -> 0.
- Mul corners: -15*15 -> -225; -16*-16 -> 256; -16*15 -> -240; 1*3 -> 3; -15*0 -> 0. o_valid exactly W+1=6 cycles after accept in every case.
- Backpressure: mul 7*-7 with i_ready=0 for 5 cycles -> o_fs=-49 held stable, o_ready=0 throughout, i_valid pulses ignored; o_ready=1 the cycle after i_ready=1.
- MAC saturation (ACC_W=10): clear, mac -16*-16 -> o_acc=256, o_ovf=0; again -> o_acc=511 (clamped), o_ovf=1; mac 1*1 -> o_acc=511, o_ovf stays 1; i_acc_clr -> o_acc=0, o_ovf=0.
- Clear collision: i_acc_clr asserted on the MAC completion edge of 3*3 -> o_fs=9, o_acc=0, o_ovf=0.

Source files
------------

// File: rtl/signed_calc_pkg.sv
// Shared encodings and helpers for the sequential signed calculator.
package signed_calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MAC = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  // Clamp a signed value into the range of a w-bit signed number (w <= 64).
  function automatic logic signed [63:0] sat(input logic signed [63:0] val,
                                             input int unsigned w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (val > max_v) return max_v;
    if (val < min_v) return min_v;
    return val;
  endfunction

endpackage

// File: rtl/signed_mul_iter.sv
// Iterative W-bit signed multiplier: magnitude shift-add, one bit per cycle, sign fix-up at the end.
module signed_mul_iter #(
  parameter int W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W);

  logic           busy;
  logic           neg;
  logic [2*W-1:0] a_sh;
  logic [W-1:0]   b_sh;
  logic [2*W-1:0] pp;
  logic [2*W-1:0] pp_next;
  logic [CW-1:0]  cnt;

  // The most negative operand has magnitude 2^(W-1), which still fits W unsigned bits.
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  // The last partial sum is folded in combinationally so the result is ready on the W-th step.
  always_comb begin
    pp_next = pp + (b_sh[0] ? a_sh : '0);
    done    = busy && (cnt == CW'(W - 1));
    product = neg ? -pp_next : pp_next;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      neg  <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      pp   <= '0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      neg  <= a[W-1] ^ b[W-1];
      a_sh <= {{W{1'b0}}, mag(a)};
      b_sh <= mag(b);
      pp   <= '0;
      cnt  <= '0;
    end else if (busy) begin
      pp   <= pp_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/signed_calc_seq.sv
// Sequential signed calculator: add/sub in one cycle, iterative mul, and a saturating MAC
// accumulator with a sticky overflow flag, behind valid/ready handshakes on both sides.
module signed_calc_seq
  import signed_calc_pkg::*;
#(
  parameter int W     = 5,
  parameter int ACC_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [W-1:0]     i_as,
  input  logic [W-1:0]     i_bs,
  input  logic             i_acc_clr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [2*W-1:0]   o_fs,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf
);

  state_t                  state;
  state_t                  state_next;
  op_t                     op;
  logic                    accept;
  logic                    is_mac;
  logic                    mul_done;
  logic                    ovf_hit;
  logic [2*W-1:0]          product;
  logic signed [2*W-1:0]   a_ext;
  logic signed [2*W-1:0]   b_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [63:0]      acc_sum;
  logic signed [63:0]      acc_sat;

  assign op      = op_t'(i_op);
  assign a_ext   = (2*W)'($signed(i_as));
  assign b_ext   = (2*W)'($signed(i_bs));
  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign accept  = i_valid && o_ready;
  assign o_acc   = acc;

  signed_mul_iter #(.W(W)) u_mul (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .start   (accept && (op == OP_MUL || op == OP_MAC)),
    .a       (i_as),
    .b       (i_bs),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: defaulting state_next first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_valid) state_next = (op == OP_ADD || op == OP_SUB) ? DONE : MUL;
      MUL:     if (mul_done) state_next = DONE;
      DONE:    if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fs   <= '0;
      is_mac <= 1'b0;
    end else if (accept) begin
      is_mac <= (op == OP_MAC);
      if (op == OP_ADD)      o_fs <= a_ext + b_ext;
      else if (op == OP_SUB) o_fs <= a_ext - b_ext;
    end else if (mul_done) begin
      o_fs <= product;
    end
  end

  // Sum at 64 bits so the clamp sees the true value before it is squeezed into ACC_W.
  always_comb begin
    acc_sum = 64'(acc) + 64'($signed(product));
    acc_sat = sat(acc_sum, ACC_W);
    ovf_hit = (acc_sat != acc_sum);
  end

  // A clear on the completion edge wins; the product still reaches o_fs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc   <= '0;
      o_ovf <= 1'b0;
    end else if (i_acc_clr) begin
      acc   <= '0;
      o_ovf <= 1'b0;
    end else if (mul_done && is_mac) begin
      acc <= acc_sat[ACC_W-1:0];
      if (ovf_hit) o_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_signed_calc_seq.sv
// Self-checking bench for signed_calc_seq: directed corners plus random ops against a latency/arithmetic model.
module tb_signed_calc_seq;

  localparam int W     = 5;
  localparam int ACC_W = 10;
  localparam int MAXA  = 511;
  localparam int MINA  = -512;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             i_valid   = 1'b0;
  logic             i_acc_clr = 1'b0;
  logic             i_ready   = 1'b0;
  logic [1:0]       i_op      = '0;
  logic [W-1:0]     i_as      = '0;
  logic [W-1:0]     i_bs      = '0;
  logic             o_ready;
  logic             o_valid;
  logic             o_ovf;
  logic [2*W-1:0]   o_fs;
  logic [ACC_W-1:0] o_acc;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: result value, visibility latency, accumulator.
  int m_fs, m_acc, m_res, m_cnt;
  bit m_valid, m_ovf, m_mac;

  always #5 clk = ~clk;

  signed_calc_seq #(.W(W), .ACC_W(ACC_W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_op      (i_op),
    .i_as      (i_as),
    .i_bs      (i_bs),
    .i_acc_clr (i_acc_clr),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_fs      (o_fs),
    .o_acc     (o_acc),
    .o_ovf     (o_ovf)
  );

  function automatic int model_result(input int op, input int a, input int b);
    case (op)
      0:       return a + b;
      1:       return a - b;
      default: return a * b;
    endcase
  endfunction

  function automatic int clamp(input int v);
    if (v > MAXA) return MAXA;
    if (v < MINA) return MINA;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_cnt   <= 0;
      m_fs    <= 0;
      m_res   <= 0;
      m_acc   <= 0;
      m_ovf   <= 1'b0;
      m_mac   <= 1'b0;
    end else begin
      if (m_valid && i_ready) m_valid <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_valid <= 1'b1;
          m_fs    <= m_res;
        end
      end else if (!m_valid && i_valid) begin
        if (i_op[1]) begin
          m_res <= model_result(i_op, $signed(i_as), $signed(i_bs));
          m_cnt <= W;
          m_mac <= (i_op == 2'b11);
        end else begin
          m_fs    <= model_result(i_op, $signed(i_as), $signed(i_bs));
          m_valid <= 1'b1;
          m_mac   <= 1'b0;
        end
      end
      if (i_acc_clr) begin
        m_acc <= 0;
        m_ovf <= 1'b0;
      end else if (m_cnt == 1 && m_mac) begin
        m_acc <= clamp(m_acc + m_res);
        m_ovf <= m_ovf | (clamp(m_acc + m_res) != m_acc + m_res);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_valid", o_valid, m_valid);
      check("cmp_ready", o_ready, (m_cnt == 0 && !m_valid));
      check("cmp_acc", $signed(o_acc), m_acc);
      check("cmp_ovf", o_ovf, m_ovf);
      if (m_valid) check("cmp_fs", $signed(o_fs), m_fs);
    end
  end

  task automatic do_op(input int op, input int a, input int b, input int stall,
                       input bit clr_done, input bit pin, input int exp_fs);
    int n;
    n = 0;
    while (!o_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_req", o_ready, 1);
    i_valid = 1'b1;
    i_op    = op[1:0];
    i_as    = a[W-1:0];
    i_bs    = b[W-1:0];
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_op    = 2'($urandom);
    i_as    = W'($urandom);
    i_bs    = W'($urandom);
    n = 1;
    while (!o_valid && n < 30) begin
      if (clr_done && n == W) i_acc_clr = 1'b1;
      @(posedge clk); #1;
      i_acc_clr = 1'b0;
      n++;
    end
    check("latency", n, (op >= 2) ? W + 1 : 1);
    if (pin) check("fs_literal", $signed(o_fs), exp_fs);
    for (int k = 0; k < stall; k++) begin
      i_valid = k[0];
      @(posedge clk); #1;
      if (pin) check("fs_held", $signed(o_fs), exp_fs);
      check("ready_low_stall", o_ready, 0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("ready_after_ack", o_ready, 1);
  endtask

  task automatic clear_acc();
    i_acc_clr = 1'b1;
    @(posedge clk); #1;
    i_acc_clr = 1'b0;
    check("acc_cleared", $signed(o_acc), 0);
    check("ovf_cleared", o_ovf, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached without finishing");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, a, b, stall;
    bit clr;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_fs", $signed(o_fs), 0);
    check("rst_acc", $signed(o_acc), 0);
    check("rst_ovf", o_ovf, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", o_ready, 1);

    do_op(0, 15, 15, 0, 1'b0, 1'b1, 30);
    do_op(1, -16, 15, 0, 1'b0, 1'b1, -31);
    do_op(0, 0, 0, 0, 1'b0, 1'b1, 0);

    do_op(2, -15, 15, 0, 1'b0, 1'b1, -225);
    do_op(2, -16, -16, 0, 1'b0, 1'b1, 256);
    do_op(2, -16, 15, 0, 1'b0, 1'b1, -240);
    do_op(2, 1, 3, 0, 1'b0, 1'b1, 3);
    do_op(2, -15, 0, 0, 1'b0, 1'b1, 0);

    do_op(2, 7, -7, 5, 1'b0, 1'b1, -49);

    clear_acc();
    do_op(3, -16, -16, 0, 1'b0, 1'b1, 256);
    check("mac1_acc", $signed(o_acc), 256);
    check("mac1_ovf", o_ovf, 0);
    do_op(3, -16, -16, 0, 1'b0, 1'b1, 256);
    check("mac2_acc", $signed(o_acc), 511);
    check("mac2_ovf", o_ovf, 1);
    do_op(3, 1, 1, 0, 1'b0, 1'b1, 1);
    check("mac3_acc", $signed(o_acc), 511);
    check("mac3_ovf", o_ovf, 1);
    clear_acc();

    do_op(3, 2, 2, 0, 1'b0, 1'b1, 4);
    check("pre_collision_acc", $signed(o_acc), 4);
    do_op(3, 3, 3, 0, 1'b1, 1'b1, 9);
    check("collision_acc", $signed(o_acc), 0);
    check("collision_ovf", o_ovf, 0);

    for (int i = 0; i < 40; i++) begin
      op    = int'($urandom_range(0, 3));
      a     = int'($urandom_range(0, 31)) - 16;
      b     = int'($urandom_range(0, 31)) - 16;
      stall = int'($urandom_range(0, 3));
      clr   = ($urandom_range(0, 7) == 0);
      do_op(op, a, b, stall, clr, 1'b0, 0);
    end

    clear_acc();
    do_op(3, 3, 3, 0, 1'b0, 1'b1, 9);
    check("pre_reset_acc", $signed(o_acc), 9);
    i_valid = 1'b1;
    i_op    = 2'b10;
    i_as    = 5'b10001;
    i_bs    = 5'b01111;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midmul_rst_valid", o_valid, 0);
    check("midmul_rst_fs", $signed(o_fs), 0);
    check("midmul_rst_acc", $signed(o_acc), 0);
    check("midmul_rst_ovf", o_ovf, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midmul_ready", o_ready, 1);
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      check("no_stale_valid", o_valid, 0);
    end

    do_op(0, 1, 2, 0, 1'b0, 1'b1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
